axi_sram_subordinate: RTL and testbench
=======================================

AXI_SRAM_SUBORDINATE -- requirements
Module: axi_sram_subordinate

Interface
REQ-001 Parameter DEPTH, default 1024, storage depth in DWIDTH-bit words; SHALL be a power of two, >= 2.
REQ-002 Port i_clk  input  1  sole clock; the connected axi_if instance SHALL be clocked by the same clock.
REQ-003 Port i_rst  input  1  reset; synchronous and active-high.
REQ-004 Port axi  axi_if.subordinate  n/a  AXI responder end; widths come from axi_pkg (AWIDTH, DWIDTH, IDWIDTH, LENWIDTH).

Function
REQ-005 Storage SHALL be DEPTH x DWIDTH; word index = addr[log2(DWIDTH/8) +: log2(DEPTH)].
REQ-006 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP; read FSM states SHALL be R_IDLE and R_DATA; the two FSMs SHALL be independent.
REQ-007 W_IDLE: awready=1; on AW handshake, latch awid, awaddr and awlen; next state W_DATA.
REQ-008 W_DATA: wready=1; each W handshake writes the bytes where wstrb[i]=1 to the current word; address advances by DWIDTH/8 per beat.
REQ-009 W_DATA exits to W_RESP on the beat where wlast=1 or the beat count reaches awlen+1, whichever comes first; wid SHALL be ignored.
REQ-010 W_RESP: bvalid=1, bid=latched awid; hold until bready; on B handshake go to W_IDLE (awready=1 in the following cycle).
REQ-011 R_IDLE: arready=1; on AR handshake, latch arid, araddr and arlen; next state R_DATA.
REQ-012 R_DATA: rvalid=1, rid=latched arid, rdata=mem[current index], rlast=1 only on beat arlen; on each R handshake advance the address; after the rlast handshake go to R_IDLE.
REQ-013 rvalid, rdata, rresp and rlast SHALL hold stable while rvalid=1 and rready=0; bvalid and bresp SHALL hold stable until bready.
REQ-014 Latency: AW handshake at cycle N gives wready=1 at N+1; last W beat at M gives bvalid=1 at M+1; AR handshake at N gives first rvalid at N+1.
REQ-015 Burst types FIXED and INCR SHALL both be treated as INCR; WRAP SHALL be treated as INCR; awsize and arsize SHALL be ignored (full-width beats only).
REQ-016 Same-cycle write and read of one word: the read beat SHALL return the pre-write data; the written value SHALL be visible from the next cycle.
REQ-017 Address increment past the top of the AWIDTH space SHALL wrap modulo 2^AWIDTH.
REQ-018 rdata SHALL be 0 whenever rvalid=0.
REQ-019 bresp and rresp SHALL be OKAY except as defined in REQ-024.

Reset
REQ-020 While i_rst=1, at the next posedge: both FSMs go idle; awready, wready, bvalid, arready, rvalid and rlast = 0; bid and rid = 0; bresp and rresp = OKAY; rdata = 0.
REQ-021 In the first cycle after i_rst deasserts, awready=1 and arready=1.
REQ-022 Reset mid-burst SHALL abandon the transaction with no B or R response; memory contents SHALL NOT be reset, and words already written SHALL keep their values.

Configuration
REQ-023 Macro AXI_SRAM_SUBORDINATE_DECERR_EN SHALL enable range checking.
REQ-024 With AXI_SRAM_SUBORDINATE_DECERR_EN defined: a beat is out of range when (addr >> log2(DWIDTH/8)) >= DEPTH; out-of-range W beats are discarded, and bresp=DECERR if any beat of the burst was out of range; out-of-range R beats return rdata=0 with rresp=DECERR for that beat only.
REQ-025 Without AXI_SRAM_SUBORDINATE_DECERR_EN: upper address bits are ignored (index modulo DEPTH), and bresp and rresp are always OKAY.

Verification
REQ-026 Single write: awaddr=0x10, awlen=0, awid=3, wdata=0xDEADBEEF, wstrb=all ones -> bvalid at the next cycle after W with bid=3, bresp=OKAY; read of 0x10 returns 0xDEADBEEF, rlast=1.
REQ-027 4-beat INCR write at 0x0 with data 1,2,3,4, then 4-beat read with rready toggling every other cycle -> rdata 1,2,3,4 held stable across stalls, rlast only on beat 3, rid equals arid.
REQ-028 Byte strobe: word holds 0xFFFFFFFF; write 0x00000000 with wstrb=0b0101 -> read returns 0xFF00FF00.
REQ-029 Backpressure: bready=0 for 5 cycles after the last W beat -> bvalid and bresp held; awready=0 until the B handshake, then 1 the next cycle.
REQ-030 Reset during the beat-2 W handshake of a 4-beat burst -> no bvalid; beats 0-1 are retained in memory; awready=1 on the first cycle after reset.
REQ-031 With AXI_SRAM_SUBORDINATE_DECERR_EN, DEPTH=16, DWIDTH=32: read at 0x40 returns rresp=DECERR, rdata=0; without the macro, the same read returns mem[0] with OKAY.

Source files
------------

// File: rtl/axi_sram_subordinate_if.sv
// AXI widths/response codes and the AXI bus bundle used between manager and subordinate.
// Burst type, size and wid are not carried: the subordinate treats every burst as full-width INCR.
package axi_pkg;
  localparam int AWIDTH   = 32;
  localparam int DWIDTH   = 32;
  localparam int IDWIDTH  = 4;
  localparam int LENWIDTH = 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

interface axi_if;
  import axi_pkg::*;

  logic                  awvalid;
  logic                  awready;
  logic [AWIDTH-1:0]     awaddr;
  logic [LENWIDTH-1:0]   awlen;
  logic [IDWIDTH-1:0]    awid;

  logic                  wvalid;
  logic                  wready;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [IDWIDTH-1:0]    bid;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [AWIDTH-1:0]     araddr;
  logic [LENWIDTH-1:0]   arlen;
  logic [IDWIDTH-1:0]    arid;

  logic                  rvalid;
  logic                  rready;
  logic [DWIDTH-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [IDWIDTH-1:0]    rid;

  modport manager (
    output awvalid, awaddr, awlen, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arlen, arid,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport subordinate (
    input  awvalid, awaddr, awlen, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arid,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/axi_sram_subordinate.sv
// AXI SRAM subordinate: independent write/read FSMs, 1-cycle AW->W, W->B and AR->R latency, all outputs registered.
// Backpressure holds B/R stable until accepted. Optional range checking under AXI_SRAM_SUBORDINATE_DECERR_EN.
module axi_sram_subordinate
  import axi_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  axi_if.subordinate  axi
);

  localparam int BYTES = DWIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);
  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(BYTES);

  logic [DWIDTH-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  w_state_e w_state_q, w_state_d;

  logic [AWIDTH-1:0]   w_addr_q, w_addr_d;
  logic [LENWIDTH-1:0] w_len_q, w_len_d;
  logic [LENWIDTH-1:0] w_cnt_q, w_cnt_d;
  logic                w_err_q, w_err_d;
  logic [IDWIDTH-1:0]  bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;

  logic aw_hs, w_hs, b_hs, w_done, w_oor, mem_we;
  logic [IW-1:0] w_idx;

  assign aw_hs  = axi.awvalid & awready_q;
  assign w_hs   = axi.wvalid & wready_q;
  assign b_hs   = axi.bready & bvalid_q;
  // wlast or reaching awlen+1 beats, whichever comes first, closes the burst
  assign w_done = w_hs & (axi.wlast | (w_cnt_q == w_len_q));
  assign w_idx  = w_addr_q[SHIFT +: IW];
`ifdef AXI_SRAM_SUBORDINATE_DECERR_EN
  assign w_oor  = (w_addr_q >> SHIFT) >= AWIDTH'(DEPTH);
`else
  assign w_oor  = 1'b0;
`endif
  assign mem_we = w_hs & ~w_oor & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)  w_state_d = W_DATA;
      W_DATA:  if (w_done) w_state_d = W_RESP;
      W_RESP:  if (b_hs)   w_state_d = W_IDLE;
      default:             w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      w_addr_d = axi.awaddr;
      w_len_d  = axi.awlen;
      w_cnt_d  = '0;
      w_err_d  = 1'b0;
      bid_d    = axi.awid;
    end else if (w_hs) begin
      w_addr_d = w_addr_q + STEP;
      w_cnt_d  = w_cnt_q + 1'b1;
      w_err_d  = w_err_q | w_oor;
      if (w_done) bresp_d = (w_err_q | w_oor) ? RESP_DECERR : RESP_OKAY;
    end
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Storage is deliberately not reset; an abandoned burst keeps beats already written.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  r_state_e r_state_q, r_state_d;

  logic [AWIDTH-1:0]   r_addr_q, r_addr_d;
  logic [LENWIDTH-1:0] r_len_q, r_len_d;
  logic [LENWIDTH-1:0] r_beat_q, r_beat_d;
  logic [IDWIDTH-1:0]  rid_q, rid_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic                rvalid_q, rvalid_d;
  logic                arready_q, arready_d;

  logic ar_hs, r_hs, r_load, r_oor;
  logic [IW-1:0] r_idx;

  assign ar_hs  = axi.arvalid & arready_q;
  assign r_hs   = axi.rready & rvalid_q;
  assign r_load = ar_hs | (r_hs & ~rlast_q);
  assign r_idx  = r_addr_d[SHIFT +: IW];
`ifdef AXI_SRAM_SUBORDINATE_DECERR_EN
  assign r_oor  = (r_addr_d >> SHIFT) >= AWIDTH'(DEPTH);
`else
  assign r_oor  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)           r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default:                      r_state_d = R_IDLE;
    endcase
  end

  // rdata is captured at the edge that issues the beat, so a same-cycle write returns the old word
  always_comb begin
    r_addr_d = r_addr_q;
    r_len_d  = r_len_q;
    r_beat_d = r_beat_q;
    rid_d    = rid_q;
    if (ar_hs) begin
      r_addr_d = axi.araddr;
      r_len_d  = axi.arlen;
      r_beat_d = '0;
      rid_d    = axi.arid;
    end else if (r_hs && !rlast_q) begin
      r_addr_d = r_addr_q + STEP;
      r_beat_d = r_beat_q + 1'b1;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (r_load) begin
      rdata_d = r_oor ? '0 : mem[r_idx];
      rresp_d = r_oor ? RESP_DECERR : RESP_OKAY;
      rlast_d = (r_beat_d == r_len_d);
    end else if (r_state_d == R_IDLE) begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      rlast_d = 1'b0;
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;

endmodule

// File: tb/tb_axi_sram_subordinate.sv
// Directed bench for axi_sram_subordinate (DEPTH=16, 32-bit data) with hand-computed expectations.
module tb_axi_sram_subordinate;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  axi_if axi();

  axi_sram_subordinate #(.DEPTH(16)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .axi   (axi)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int t = 0;
    axi.awaddr = a; axi.awlen = len; axi.awid = id; axi.awvalid = 1'b1;
    while (!axi.awready && t < 50) begin tick(); t++; end
    chk_eq("aw_accept", 64'(t < 50), 64'd1);
    tick();
    axi.awvalid = 1'b0;
    chk_eq("aw_to_wready", 64'(axi.wready), 64'd1);
  endtask

  // expect_b: whether bvalid must appear the cycle after this beat
  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last, input logic expect_b);
    int t = 0;
    axi.wdata = d; axi.wstrb = s; axi.wlast = last; axi.wvalid = 1'b1;
    while (!axi.wready && t < 50) begin tick(); t++; end
    chk_eq("w_accept", 64'(t < 50), 64'd1);
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    chk_eq("w_to_bvalid", 64'(axi.bvalid), 64'(expect_b));
  endtask

  task automatic wait_b(input logic [3:0] id, input logic [1:0] resp);
    int t = 0;
    axi.bready = 1'b1;
    while (!axi.bvalid && t < 50) begin tick(); t++; end
    chk_eq("b_seen", 64'(t < 50), 64'd1);
    chk_eq("bid", 64'(axi.bid), 64'(id));
    chk_eq("bresp", 64'(axi.bresp), 64'(resp));
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    int t = 0;
    axi.araddr = a; axi.arlen = len; axi.arid = id; axi.arvalid = 1'b1;
    while (!axi.arready && t < 50) begin tick(); t++; end
    chk_eq("ar_accept", 64'(t < 50), 64'd1);
    tick();
    axi.arvalid = 1'b0;
    chk_eq("ar_to_rvalid", 64'(axi.rvalid), 64'd1);
  endtask

  task automatic read1(input logic [31:0] a, input logic [3:0] id, input logic [31:0] exp_d, input logic [1:0] exp_r);
    do_ar(a, 8'd0, id);
    axi.rready = 1'b1;
    chk_eq("r1_data", 64'(axi.rdata), 64'(exp_d));
    chk_eq("r1_resp", 64'(axi.rresp), 64'(exp_r));
    chk_eq("r1_last", 64'(axi.rlast), 64'd1);
    chk_eq("r1_id", 64'(axi.rid), 64'(id));
    tick();
    axi.rready = 1'b0;
    chk_eq("r1_idle_rvalid", 64'(axi.rvalid), 64'd0);
    chk_eq("r1_idle_rdata", 64'(axi.rdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    axi.awvalid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awid = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
    axi.bready = 0;
    axi.arvalid = 0; axi.araddr = 0; axi.arlen = 0; axi.arid = 0;
    axi.rready = 0;

    // reset state
    i_rst = 1'b1;
    tick(); tick();
    chk_eq("rst_awready", 64'(axi.awready), 64'd0);
    chk_eq("rst_arready", 64'(axi.arready), 64'd0);
    chk_eq("rst_wready", 64'(axi.wready), 64'd0);
    chk_eq("rst_bvalid", 64'(axi.bvalid), 64'd0);
    chk_eq("rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk_eq("rst_rdata", 64'(axi.rdata), 64'd0);
    i_rst = 1'b0;
    tick();
    chk_eq("post_rst_awready", 64'(axi.awready), 64'd1);
    chk_eq("post_rst_arready", 64'(axi.arready), 64'd1);

    // single write / read
    do_aw(32'h10, 8'd0, 4'd3);
    do_w(32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    wait_b(4'd3, 2'b00);
    read1(32'h10, 4'd5, 32'hDEADBEEF, 2'b00);

    // 4-beat burst, read back with rready stalls
    do_aw(32'h0, 8'd3, 4'd2);
    for (int i = 0; i < 4; i++) do_w(32'(i + 1), 4'hF, 1'(i == 3), 1'(i == 3));
    wait_b(4'd2, 2'b00);
    do_ar(32'h0, 8'd3, 4'd7);
    for (int i = 0; i < 4; i++) begin
      axi.rready = 1'b0;
      tick();
      chk_eq("burst_stall_rvalid", 64'(axi.rvalid), 64'd1);
      chk_eq("burst_stall_data", 64'(axi.rdata), 64'(i + 1));
      chk_eq("burst_stall_last", 64'(axi.rlast), 64'(i == 3));
      axi.rready = 1'b1;
      chk_eq("burst_data", 64'(axi.rdata), 64'(i + 1));
      chk_eq("burst_rid", 64'(axi.rid), 64'd7);
      tick();
    end
    axi.rready = 1'b0;
    chk_eq("burst_end_rvalid", 64'(axi.rvalid), 64'd0);

    // byte strobes
    do_aw(32'h20, 8'd0, 4'd1);
    do_w(32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
    wait_b(4'd1, 2'b00);
    do_aw(32'h20, 8'd0, 4'd1);
    do_w(32'h00000000, 4'b0101, 1'b1, 1'b1);
    wait_b(4'd1, 2'b00);
    read1(32'h20, 4'd4, 32'hFF00FF00, 2'b00);

    // early wlast closes a 4-beat burst after beat 1
    do_aw(32'h24, 8'd3, 4'd6);
    do_w(32'h55, 4'hF, 1'b0, 1'b0);
    do_w(32'h66, 4'hF, 1'b1, 1'b1);
    wait_b(4'd6, 2'b00);
    read1(32'h28, 4'd6, 32'h66, 2'b00);

    // B backpressure
    do_aw(32'h30, 8'd0, 4'd9);
    do_w(32'h1234, 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp_bvalid", 64'(axi.bvalid), 64'd1);
      chk_eq("bp_bresp", 64'(axi.bresp), 64'd0);
      chk_eq("bp_awready", 64'(axi.awready), 64'd0);
      tick();
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk_eq("bp_awready_after", 64'(axi.awready), 64'd1);
    chk_eq("bp_bvalid_after", 64'(axi.bvalid), 64'd0);

    // reset on beat 2 of a 4-beat burst
    do_aw(32'h08, 8'd3, 4'd1);
    do_w(32'hA0, 4'hF, 1'b0, 1'b0);
    do_w(32'hA1, 4'hF, 1'b0, 1'b0);
    axi.wdata = 32'hA2; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    i_rst = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    chk_eq("mid_rst_bvalid", 64'(axi.bvalid), 64'd0);
    tick();
    i_rst = 1'b0;
    tick();
    chk_eq("mid_rst_awready", 64'(axi.awready), 64'd1);
    chk_eq("mid_rst_no_b", 64'(axi.bvalid), 64'd0);
    read1(32'h08, 4'd2, 32'hA0, 2'b00);
    read1(32'h0C, 4'd2, 32'hA1, 2'b00);

    // address beyond DEPTH words
`ifdef AXI_SRAM_SUBORDINATE_DECERR_EN
    read1(32'h40, 4'd8, 32'h0, 2'b11);
`else
    read1(32'h40, 4'd8, 32'h1, 2'b00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
